// File: rtl/cache_pkg.sv
// Shared types for the cache miss-handling controller: state encoding and memory request kinds.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WB_REQ     = 3'd1,
        WB_DATA    = 3'd2,
        RF_REQ     = 3'd3,
        RF_DATA    = 3'd4,
        ALLOC_DONE = 3'd5
    } t_cache_state;

    // Value driven on o_mem_req_write for each burst kind.
    localparam logic MEM_REQ_WB = 1'b1;
    localparam logic MEM_REQ_RF = 1'b0;

endpackage

// File: rtl/cache_fsm_beat_counter.sv
// Beat index counter for writeback/refill bursts; wraps from the last beat back to 0.
// Latency: count updates on the clock edge after inc/clear; last is combinational from the count.
// Backpressure: holds its value whenever inc is low, so stalls of any length are harmless.
module beat_counter #(
    parameter  int BLOCK_WORDS = 16,
    localparam int CNT_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, the last beat wraps explicitly to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/cache_fsm.sv
// Cache miss controller: resolves hits in the request cycle, otherwise writes back a dirty victim and refills the line.
// Latency: hit 0 extra cycles; miss holds o_stall through request wait, burst beats and one ALLOC_DONE cycle.
// Backpressure: request valids hold until ready; beats advance only on wready/rvalid; no abort once a burst starts.
module cache_fsm
    import cache_pkg::*;
#(
    parameter  int BLOCK_WORDS = 16,
    localparam int CNT_W       = $clog2(BLOCK_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start_check,
    input  logic             i_write,
    input  logic             i_hit,
    input  logic             i_dirty,
    output logic             o_stall,
    output logic             o_data_we,
    output logic             o_dirty_set,
    output logic             o_dirty_clr,
    output logic             o_lru_update,
    output logic             o_tag_we,
    output logic             o_addr_sel,
    output logic             o_mem_req_valid,
    output logic             o_mem_req_write,
    input  logic             i_mem_req_ready,
    output logic             o_mem_wvalid,
    input  logic             i_mem_wready,
    input  logic             i_mem_rvalid,
    output logic             o_mem_rready,
    output logic             o_refill_we,
    output logic [CNT_W-1:0] o_beat_idx
);

    t_cache_state     state_q;
    t_cache_state     state_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    beat_counter #(
        .BLOCK_WORDS(BLOCK_WORDS)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .last (cnt_last)
    );

    // State register; reset returns to IDLE from anywhere, including mid-burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and beat counter control; i_start_check is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start_check && !i_hit) begin
                    state_d = i_dirty ? WB_REQ : RF_REQ;
                end
            end
            WB_REQ: begin
                if (i_mem_req_ready) begin
                    state_d = WB_DATA;
                    cnt_clr = 1'b1;
                end
            end
            WB_DATA: begin
                if (i_mem_wready) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = RF_REQ;
                    end
                end
            end
            RF_REQ: begin
                if (i_mem_req_ready) begin
                    state_d = RF_DATA;
                    cnt_clr = 1'b1;
                end
            end
            RF_DATA: begin
                if (i_mem_rvalid) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ALLOC_DONE;
                    end
                end
            end
            ALLOC_DONE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; all forced low while reset is asserted.
    always_comb begin
        o_stall         = 1'b0;
        o_data_we       = 1'b0;
        o_dirty_set     = 1'b0;
        o_dirty_clr     = 1'b0;
        o_lru_update    = 1'b0;
        o_tag_we        = 1'b0;
        o_addr_sel      = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_req_write = 1'b0;
        o_mem_wvalid    = 1'b0;
        o_mem_rready    = 1'b0;
        o_refill_we     = 1'b0;
        o_beat_idx      = '0;
        if (!rst) begin
            o_beat_idx = cnt;
            case (state_q)
                IDLE: begin
                    if (i_start_check) begin
                        if (i_hit) begin
                            o_lru_update = 1'b1;
                            o_data_we    = i_write;
                            o_dirty_set  = i_write;
                        end else begin
                            o_stall = 1'b1;
                        end
                    end
                end
                WB_REQ: begin
                    o_stall         = 1'b1;
                    o_mem_req_valid = 1'b1;
                    o_mem_req_write = MEM_REQ_WB;
                    o_addr_sel      = 1'b1;
                end
                WB_DATA: begin
                    o_stall      = 1'b1;
                    o_mem_wvalid = 1'b1;
                    o_addr_sel   = 1'b1;
                    o_dirty_clr  = i_mem_wready && cnt_last;
                end
                RF_REQ: begin
                    o_stall         = 1'b1;
                    o_mem_req_valid = 1'b1;
                    o_mem_req_write = MEM_REQ_RF;
                end
                RF_DATA: begin
                    o_stall      = 1'b1;
                    o_mem_rready = 1'b1;
                    o_refill_we  = i_mem_rvalid;
                    o_tag_we     = i_mem_rvalid && cnt_last;
                end
                ALLOC_DONE: o_stall = 1'b1;
                default:    o_stall = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fsm.sv
module tb_cache_fsm;

    typedef struct packed {
        logic       stall, data_we, dirty_set, dirty_clr, lru, tag_we;
        logic       addr_sel, req_valid, req_write, wvalid, rready, refill_we;
        logic [3:0] beat;
    } outs_t;

    // in = {rst, start, write, hit, dirty, req_ready, wready, rvalid}
    typedef struct {
        string       name;
        logic [7:0]  in;
        logic [11:0] flags;
        logic [3:0]  beat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, write = 1'b0, hit = 1'b0, dirty = 1'b0;
    logic req_ready = 1'b0, wready = 1'b0, rvalid = 1'b0;
    logic o_stall, o_data_we, o_dirty_set, o_dirty_clr, o_lru_update, o_tag_we, o_addr_sel;
    logic o_mem_req_valid, o_mem_req_write, o_mem_wvalid, o_mem_rready, o_refill_we;
    logic [3:0] o_beat_idx;

    logic rst2 = 1'b1, start2 = 1'b0, hit2 = 1'b0;
    logic o2_stall, o2_data_we, o2_dirty_set, o2_dirty_clr, o2_lru_update, o2_tag_we, o2_addr_sel;
    logic o2_mem_req_valid, o2_mem_req_write, o2_mem_wvalid, o2_mem_rready, o2_refill_we;
    logic [0:0] o2_beat_idx;

    int tests = 0;
    int fails = 0;
    int stall_seen = 0;

    always #5 clk = ~clk;

    cache_fsm #(.BLOCK_WORDS(16)) dut (
        .clk(clk), .rst(rst), .i_start_check(start), .i_write(write), .i_hit(hit), .i_dirty(dirty),
        .o_stall(o_stall), .o_data_we(o_data_we), .o_dirty_set(o_dirty_set), .o_dirty_clr(o_dirty_clr),
        .o_lru_update(o_lru_update), .o_tag_we(o_tag_we), .o_addr_sel(o_addr_sel),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_write(o_mem_req_write), .i_mem_req_ready(req_ready),
        .o_mem_wvalid(o_mem_wvalid), .i_mem_wready(wready), .i_mem_rvalid(rvalid),
        .o_mem_rready(o_mem_rready), .o_refill_we(o_refill_we), .o_beat_idx(o_beat_idx)
    );

    cache_fsm #(.BLOCK_WORDS(2)) dut2 (
        .clk(clk), .rst(rst2), .i_start_check(start2), .i_write(1'b0), .i_hit(hit2), .i_dirty(1'b0),
        .o_stall(o2_stall), .o_data_we(o2_data_we), .o_dirty_set(o2_dirty_set), .o_dirty_clr(o2_dirty_clr),
        .o_lru_update(o2_lru_update), .o_tag_we(o2_tag_we), .o_addr_sel(o2_addr_sel),
        .o_mem_req_valid(o2_mem_req_valid), .o_mem_req_write(o2_mem_req_write), .i_mem_req_ready(1'b1),
        .o_mem_wvalid(o2_mem_wvalid), .i_mem_wready(1'b1), .i_mem_rvalid(1'b1),
        .o_mem_rready(o2_mem_rready), .o_refill_we(o2_refill_we), .o_beat_idx(o2_beat_idx)
    );

    // Inputs are applied on the falling edge; outputs are sampled 1 time unit later.
    task automatic chk(input string nm, input outs_t e);
        outs_t g;
        #1;
        g = {o_stall, o_data_we, o_dirty_set, o_dirty_clr, o_lru_update, o_tag_we,
             o_addr_sel, o_mem_req_valid, o_mem_req_write, o_mem_wvalid, o_mem_rready, o_refill_we,
             o_beat_idx};
        tests++;
        if (o_stall) stall_seen++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %b want %b", nm, g, e);
        end
        @(negedge clk);
    endtask

    task automatic cmp_int(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // One full miss starting in IDLE: optional writeback, refill, ALLOC_DONE, final IDLE cycle.
    task automatic run_miss(input string nm, input bit dirty_i, input bit write_i, input bit bp,
                            input int req_wait, input bit hold, output int stalls);
        outs_t e;
        int    beat;
        int    guard;
        stall_seen = 0;
        start = 1'b1; hit = 1'b0; dirty = dirty_i; write = write_i;
        req_ready = 1'b0; wready = 1'b0; rvalid = 1'b0;
        e = '0; e.stall = 1'b1;
        chk({nm, "/miss"}, e);
        start = hold;
        if (dirty_i) begin
            for (int k = 0; k <= req_wait; k++) begin
                req_ready = (k == req_wait);
                e = '0; e.stall = 1'b1; e.addr_sel = 1'b1; e.req_valid = 1'b1; e.req_write = 1'b1;
                chk($sformatf("%s/wb_req%0d", nm, k), e);
            end
            req_ready = 1'b0;
            beat = 0; guard = 0;
            while (beat < 16 && guard < 200) begin
                wready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                e = '0; e.stall = 1'b1; e.wvalid = 1'b1; e.addr_sel = 1'b1; e.beat = 4'(beat);
                e.dirty_clr = wready && (beat == 15);
                chk($sformatf("%s/wb_beat%0d", nm, beat), e);
                if (wready) beat++;
                guard++;
            end
            wready = 1'b0;
            cmp_int({nm, "/wb_beats"}, beat, 16);
        end
        for (int k = 0; k <= req_wait; k++) begin
            req_ready = (k == req_wait);
            e = '0; e.stall = 1'b1; e.req_valid = 1'b1;
            chk($sformatf("%s/rf_req%0d", nm, k), e);
        end
        req_ready = 1'b0;
        beat = 0; guard = 0;
        while (beat < 16 && guard < 200) begin
            rvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            e = '0; e.stall = 1'b1; e.rready = 1'b1; e.beat = 4'(beat);
            e.refill_we = rvalid;
            e.tag_we = rvalid && (beat == 15);
            chk($sformatf("%s/rf_beat%0d", nm, beat), e);
            if (rvalid) beat++;
            guard++;
        end
        rvalid = 1'b0;
        cmp_int({nm, "/rf_beats"}, beat, 16);
        hit = 1'b1;
        e = '0; e.stall = 1'b1;
        chk({nm, "/alloc_done"}, e);
        e = '0;
        if (hold) begin
            e.lru = 1'b1; e.data_we = write_i; e.dirty_set = write_i;
        end
        chk({nm, "/complete"}, e);
        start = 1'b0; hit = 1'b0; write = 1'b0; dirty = 1'b0;
        stalls = stall_seen;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[13];
        outs_t e;
        int    s;
        int    st2, rf2, tag_beat;

        tbl[0]  = '{"reset",        8'b1000_0000, 12'b0000_0000_0000, 4'd0};
        tbl[1]  = '{"idle",         8'b0000_0000, 12'b0000_0000_0000, 4'd0};
        tbl[2]  = '{"load_hit",     8'b0101_0000, 12'b0000_1000_0000, 4'd0};
        tbl[3]  = '{"store_hit",    8'b0111_0000, 12'b0110_1000_0000, 4'd0};
        tbl[4]  = '{"dirty_miss",   8'b0110_1000, 12'b1000_0000_0000, 4'd0};
        tbl[5]  = '{"wb_req_wait0", 8'b0110_1000, 12'b1000_0011_1000, 4'd0};
        tbl[6]  = '{"wb_req_wait1", 8'b0110_1000, 12'b1000_0011_1000, 4'd0};
        tbl[7]  = '{"wb_req_rdy",   8'b0110_1100, 12'b1000_0011_1000, 4'd0};
        tbl[8]  = '{"wb_data_hold", 8'b0110_1000, 12'b1000_0010_0100, 4'd0};
        tbl[9]  = '{"wb_data_beat", 8'b0110_1010, 12'b1000_0010_0100, 4'd0};
        tbl[10] = '{"wb_data_next", 8'b0110_1000, 12'b1000_0010_0100, 4'd1};
        tbl[11] = '{"rst_mid_wb",   8'b1110_1000, 12'b0000_0000_0000, 4'd0};
        tbl[12] = '{"idle_after",   8'b0000_0000, 12'b0000_0000_0000, 4'd0};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            {rst, start, write, hit, dirty, req_ready, wready, rvalid} = tbl[i].in;
            chk(tbl[i].name, {tbl[i].flags, tbl[i].beat});
        end
        {rst, start, write, hit, dirty, req_ready, wready, rvalid} = 8'b0;

        run_miss("clean_load", 1'b0, 1'b0, 1'b0, 2, 1'b1, s);
        cmp_int("clean_load/stall_cycles", s, 21);

        run_miss("dirty_store", 1'b1, 1'b1, 1'b0, 0, 1'b1, s);
        cmp_int("dirty_store/stall_cycles", s, 36);

        run_miss("backpressure_drop", 1'b1, 1'b0, 1'b1, 1, 1'b0, s);

        // Reset during refill at beat 7, then a fresh miss must restart at beat 0.
        start = 1'b1; hit = 1'b0; dirty = 1'b0;
        e = '0; e.stall = 1'b1;
        chk("rstmid/miss", e);
        req_ready = 1'b1;
        e = '0; e.stall = 1'b1; e.req_valid = 1'b1;
        chk("rstmid/rf_req", e);
        req_ready = 1'b0;
        for (int b = 0; b < 7; b++) begin
            rvalid = 1'b1;
            e = '0; e.stall = 1'b1; e.rready = 1'b1; e.refill_we = 1'b1; e.beat = 4'(b);
            chk($sformatf("rstmid/rf_beat%0d", b), e);
        end
        rst = 1'b1;
        chk("rstmid/during_rst", '0);
        rst = 1'b0; start = 1'b0; rvalid = 1'b0;
        chk("rstmid/idle_after", '0);
        run_miss("after_rst", 1'b0, 1'b0, 1'b0, 0, 1'b1, s);
        cmp_int("after_rst/stall_cycles", s, 19);

        // Two-word line build with ready and rvalid held high.
        st2 = 0; rf2 = 0; tag_beat = -1;
        rst2 = 1'b0; start2 = 1'b1; hit2 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (o2_stall) st2++;
            if (o2_refill_we) begin
                cmp_int($sformatf("bw2/refill_idx%0d", rf2), int'(o2_beat_idx), rf2);
                rf2++;
            end
            if (o2_tag_we) tag_beat = int'(o2_beat_idx);
            @(negedge clk);
            hit2 = 1'b1;
        end
        cmp_int("bw2/stall_cycles", st2, 5);
        cmp_int("bw2/refill_beats", rf2, 2);
        cmp_int("bw2/tag_we_beat", tag_beat, 1);
        #1;
        cmp_int("bw2/idx_wrapped", int'(o2_beat_idx), 0);
        start2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
